// File: rtl/seg7_display_ctrl.sv
// Multi-digit hex 7-segment controller: load-captured shadow data, font, LZ blanking, blink.
// Define SEG7_SCAN_EN to add the time-multiplexed oSEG_MUX/oDIG_SEL scan outputs.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ACTIVE_LOW = 1,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iDIGITS,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
  input  logic                    iBLANK_LZ,
  input  logic                    iLOAD,
  output logic [8*NUM_DIGITS-1:0] oSEG,
  output logic [7:0]              oSEG_MUX,
  output logic [NUM_DIGITS-1:0]   oDIG_SEL
);

  localparam logic POL = (ACTIVE_LOW != 0);
  localparam int   BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_display_ctrl: NUM_DIGITS must be 1..8");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("seg7_display_ctrl: BLINK_DIV must be >= 2");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan
    $error("seg7_display_ctrl: SCAN_DIV must be >= 1");
  end

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic                    lz_q;
  logic                    valid;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [8*NUM_DIGITS-1:0] seg_next;

  function automatic logic [6:0] font(input logic [3:0] nib);
    case (nib)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  // Walk from the most significant digit down so lz_run means "this and all higher digits are 0".
  always_comb begin
    int unsigned n;
    logic        lz_run;
    logic [3:0]  nib;
    logic [7:0]  byte_hi;
    seg_next = '0;
    n        = 0;
    lz_run   = 1'b1;
    nib      = '0;
    byte_hi  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      n      = NUM_DIGITS - 1 - i;
      nib    = digits_q[4*n +: 4];
      lz_run = lz_run & (nib == 4'h0);
      if (!valid || (blink_phase && mask_q[n]))
        byte_hi = 8'h00;
      else if (lz_q && lz_run && n != 0)
        byte_hi = {dp_q[n], 7'h00};
      else
        byte_hi = {dp_q[n], font(nib)};
      seg_next[8*n +: 8] = byte_hi ^ {8{POL}};
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      digits_q    <= '0;
      dp_q        <= '0;
      mask_q      <= '0;
      lz_q        <= 1'b0;
      valid       <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      oSEG        <= {8*NUM_DIGITS{POL}};
    end else begin
      if (iLOAD) begin
        digits_q <= iDIGITS;
        dp_q     <= iDP;
        mask_q   <= iBLINK_MASK;
        lz_q     <= iBLANK_LZ;
        valid    <= 1'b1;
      end
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      oSEG <= seg_next;
    end
  end

`ifdef SEG7_SCAN_EN
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;

  // Mux byte is taken from seg_next so it lines up with the oSEG value registered on the same edge.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      oDIG_SEL <= {NUM_DIGITS{POL}};
      oSEG_MUX <= {8{POL}};
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      oDIG_SEL <= valid ? ((NUM_DIGITS'(1) << scan_idx) ^ {NUM_DIGITS{POL}})
                        : {NUM_DIGITS{POL}};
      oSEG_MUX <= seg_next[8*scan_idx +: 8];
    end
  end
`else
  assign oSEG_MUX = {8{POL}};
  assign oDIG_SEL = {NUM_DIGITS{POL}};
`endif

endmodule
